// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Operation encodings, FSM states and iteration constants.
package multdiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_DIV   = 2'b01,
    MD_MULTU = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } md_state_t;

  localparam int          MD_ITER  = 32;
  localparam logic [31:0] MD_DZ_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/md_iter_step.sv
// One combinational iteration of the multiply/divide engine: a shift-add
// multiply step or a restoring shift/trial-subtract divide step.
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;

  // trial subtracts from the upper half as it would look after the left shift
  assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
  assign trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};

  always_comb begin
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (!trial[WIDTH]) acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32x32 MULT/DIV unit with HI/LO registers (IDLE -> CALC -> FIX).
// Define MULTDIV_UNSIGNED_EN to make MD_MULTU/MD_DIVU execute unsigned.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int              CNT_W    = $clog2(MD_ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITER - 1);

  md_state_t          state, state_next;
  logic [CNT_W-1:0]   counter;
  logic [2*WIDTH-1:0] acc, acc_next, prod_fix;
  logic [WIDTH-1:0]   mag_b, mag_a_in, mag_b_in, hi_fix, lo_fix;
  logic               is_div, neg_q, neg_r, dz_op;
  logic               signed_op, sign_a, sign_b, dz_in, accept, last, finish;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return '0 - x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] x);
    return '0 - x;
  endfunction

`ifdef MULTDIV_UNSIGNED_EN
  assign signed_op = ~op[1];
`else
  logic unused_op_sel;
  assign unused_op_sel = op[1];
  assign signed_op     = 1'b1;
`endif

  assign sign_a   = signed_op & opA[WIDTH-1];
  assign sign_b   = signed_op & opB[WIDTH-1];
  assign mag_a_in = sign_a ? neg_w(opA) : opA;
  assign mag_b_in = sign_b ? neg_w(opB) : opB;
  assign dz_in    = op[0] && (opB == '0);
  assign accept   = (state == IDLE) && start;
  assign last     = (counter == CNT_LAST);
  // divide-by-zero enters FIX with counter 0 and dwells one cycle there
  assign finish   = (state == FIX) && (!dz_op || counter != '0);

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (mag_b),
    .is_div   (is_div),
    .acc_next (acc_next)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = dz_in ? FIX : CALC;
      CALC:    if (last) state_next = FIX;
      FIX:     if (finish) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    prod_fix = neg_q ? neg_d(acc) : acc;
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      if (dz_op) begin
        hi_fix = neg_r ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        lo_fix = MD_DZ_LO;
      end else begin
        hi_fix = neg_r ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        lo_fix = neg_q ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      counter     <= '0;
      acc         <= '0;
      mag_b       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz_op       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          acc         <= {{WIDTH{1'b0}}, mag_a_in};
          mag_b       <= mag_b_in;
          is_div      <= op[0];
          neg_q       <= sign_a ^ sign_b;
          neg_r       <= sign_a;
          dz_op       <= dz_in;
          div_by_zero <= 1'b0;
          counter     <= '0;
        end
        CALC: begin
          acc  <= acc_next;
          busy <= 1'b1;
          if (!last) counter <= counter + 1'b1;
        end
        FIX: begin
          if (finish) begin
            hi          <= hi_fix;
            lo          <= lo_fix;
            done        <= 1'b1;
            busy        <= 1'b0;
            div_by_zero <= dz_op;
          end else begin
            counter <= counter + 1'b1;
            busy    <= 1'b1;
          end
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit plus hand-written sequences
// for divide-by-zero hold, ignored start while busy and reset mid-operation.
module tb_mult_div_unit;
  import multdiv_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset, start;
  md_op_t      op;
  logic [31:0] opA, opB;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .start       (start),
    .op          (op),
    .opA         (opA),
    .opB         (opB),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  typedef struct {
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
    int          busy_cyc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drives start for one edge from the current negedge; returns at the sample after accept.
  task automatic launch(input md_op_t o, input logic [31:0] a, input logic [31:0] b);
    op    = o;
    opA   = a;
    opB   = b;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cyc);
    lat      = 0;
    busy_cyc = busy ? 1 : 0;
    while (!done && lat < 100) begin
      @(negedge Clk);
      lat++;
      if (busy) busy_cyc++;
    end
    if (!done) lat = -1;
  endtask

  initial begin
    int lat, bcyc, ndone, first_lat;

    vecs.push_back('{MD_MULT, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 32});
    vecs.push_back('{MD_DIV,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 32});
    vecs.push_back('{MD_DIV,  32'd5,          32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, 2,  1});
    vecs.push_back('{MD_MULT, 32'd3,          32'd4,         32'd0,         32'd12,        1'b0, 33, 32});
    vecs.push_back('{MD_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33, 32});
    vecs.push_back('{MD_DIV,  32'd100,        32'd7,         32'd2,         32'd14,        1'b0, 33, 32});
    vecs.push_back('{MD_DIV,  32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 33, 32});
    vecs.push_back('{MD_MULT, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 33, 32});
    vecs.push_back('{MD_MULT, 32'h0001_0000,  32'h0001_0000, 32'd1,         32'd0,         1'b0, 33, 32});
    vecs.push_back('{MD_DIV,  32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 2,  1});
    vecs.push_back('{MD_DIV,  32'd0,          32'd5,         32'd0,         32'd0,         1'b0, 33, 32});
    vecs.push_back('{MD_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 33, 32});
    vecs.push_back('{MD_MULT, 32'h8000_0000,  32'd1,         32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 33, 32});
`ifdef MULTDIV_UNSIGNED_EN
    vecs.push_back('{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,         1'b0, 33, 32});
    vecs.push_back('{MD_DIVU,  32'hFFFF_FFFF, 32'd2,         32'd1,         32'h7FFF_FFFF, 1'b0, 33, 32});
`else
    vecs.push_back('{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0, 33, 32});
    vecs.push_back('{MD_DIVU,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'd0,         1'b0, 33, 32});
`endif

    Reset = 1'b1;
    start = 1'b0;
    op    = MD_MULT;
    opA   = '0;
    opB   = '0;
    repeat (2) @(negedge Clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz",   {31'd0, div_by_zero}, 32'd0);
    check("rst_hi",   hi, 32'd0);
    check("rst_lo",   lo, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // back-to-back: each op is launched at the sample where the previous done was seen
    for (int i = 0; i < vecs.size(); i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(lat, bcyc);
      check($sformatf("v%0d_lat", i),  32'(lat),  32'(vecs[i].lat));
      check($sformatf("v%0d_busy", i), 32'(bcyc), 32'(vecs[i].busy_cyc));
      check($sformatf("v%0d_hi", i),   hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i),   lo, vecs[i].lo);
      check($sformatf("v%0d_dz", i),   {31'd0, div_by_zero}, {31'd0, vecs[i].dz});
    end

    // divide-by-zero flag holds until the next accepted start
    @(negedge Clk);
    launch(MD_DIV, 32'd5, 32'd0);
    wait_done(lat, bcyc);
    repeat (3) @(negedge Clk);
    check("dz_hold_flag", {31'd0, div_by_zero}, 32'd1);
    check("dz_hold_done", {31'd0, done}, 32'd0);
    check("dz_hold_hi",   hi, 32'd5);
    launch(MD_MULT, 32'd2, 32'd3);
    check("dz_clear_at_accept", {31'd0, div_by_zero}, 32'd0);
    wait_done(lat, bcyc);
    check("dz_next_lo", lo, 32'd6);
    @(negedge Clk);
    check("done_single_pulse", {31'd0, done}, 32'd0);
    check("lo_held", lo, 32'd6);

    // start pulsed while busy is ignored
    launch(MD_MULT, 32'd7, 32'hFFFF_FFFD);
    ndone     = 0;
    first_lat = -1;
    for (int c = 1; c <= 80; c++) begin
      if (c == 5) begin
        op = MD_DIV; opA = 32'd100; opB = 32'd7; start = 1'b1;
      end
      @(negedge Clk);
      start = 1'b0;
      if (done) begin
        ndone++;
        if (first_lat < 0) first_lat = c;
      end
    end
    check("busy_start_dones", 32'(ndone), 32'd1);
    check("busy_start_lat",   32'(first_lat), 32'd33);
    check("busy_start_hi",    hi, 32'hFFFF_FFFF);
    check("busy_start_lo",    lo, 32'hFFFF_FFEB);
    check("busy_start_idle",  {31'd0, busy}, 32'd0);

    // reset mid-operation aborts it and clears HI/LO
    launch(MD_MULT, 32'd5, 32'd6);
    repeat (9) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_hi",   hi, 32'd0);
    check("rst_mid_lo",   lo, 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clk);
      if (done) ndone++;
    end
    check("rst_mid_no_done", 32'(ndone), 32'd0);
    launch(MD_MULT, 32'd5, 32'd6);
    wait_done(lat, bcyc);
    check("post_rst_lat", 32'(lat), 32'd33);
    check("post_rst_lo",  lo, 32'd30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
